// File: rtl/apu_sample_fifo_pkg.sv
// Shared constants and head-register control encoding for the APU sample FIFO.
// Imported by the interface, the storage array and the FIFO top.
package apu_sample_fifo_pkg;

  localparam int APU_SAMPLE_W   = 16;
  localparam int APU_FIFO_DEPTH = 8;

  // What the head register does on the next edge.
  typedef enum logic [1:0] {
    HEAD_HOLD,
    HEAD_FROM_MEM,
    HEAD_FROM_WDATA,
    HEAD_EMPTY
  } head_op_e;

  function automatic int level_bits(input int depth);
    return $clog2(depth + 2);
  endfunction

endpackage

// File: rtl/apu_sample_fifo_if.sv
// Producer/consumer handshake bundle between the mixer, the sample FIFO and apu_aout.
// The master side drives data and the pop pulse; the FIFO (slave) drives wrdy and the head sample.
interface apu_sample_fifo_if
  import apu_sample_fifo_pkg::*;
#(
  parameter int W = APU_SAMPLE_W
);
  logic [W-1:0] wdata;
  logic         wvalid;
  logic         wrdy;
  logic [W-1:0] sample;
  logic         sample_rdy;

  modport master (output wdata, output wvalid, input wrdy, input sample, output sample_rdy);
  modport slave  (input wdata, input wvalid, output wrdy, output sample, input sample_rdy);
endinterface

// File: rtl/apu_fifo_mem.sv
// DEPTH x W sample storage: synchronous write, combinational read at the read pointer.
// Pointer, count and head bookkeeping live in apu_sample_fifo.
module apu_fifo_mem
  import apu_sample_fifo_pkg::*;
#(
  parameter  int DEPTH = APU_FIFO_DEPTH,
  parameter  int W     = APU_SAMPLE_W,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem_reg [DEPTH];

  // No reset: contents are only ever read behind a non-zero count.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_reg[waddr] <= wdata;
    end
  end

  assign rdata = mem_reg[raddr];

endmodule

// File: rtl/apu_sample_fifo.sv
// Sample buffer between the APU mixer and apu_aout: DEPTH queued samples plus a
// registered head that drives apu_aout, with underflow repeat and low-water request.
module apu_sample_fifo
  import apu_sample_fifo_pkg::*;
#(
  parameter  int DEPTH = APU_FIFO_DEPTH,
  parameter  int W     = APU_SAMPLE_W,
  localparam int LW    = $clog2(DEPTH + 2)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  apu_sample_fifo_if.slave     bus,
  input  logic [LW-1:0]        lowwater,
  output logic [LW-1:0]        level,
  output logic                 req_refill,
  output logic                 underflow,
  input  logic                 underflow_clr
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [PW-1:0] rptr_reg, rptr_next;
  logic [PW-1:0] wptr_reg, wptr_next;
  logic [CW-1:0] count_reg, count_next;
  logic          head_valid_reg, head_valid_next;
  logic [W-1:0]  sample_reg, sample_next;
  logic          underflow_reg, underflow_next;

  logic          pop;
  logic          wrdy;
  logic          xfer;
  logic          bypass;
  logic          mem_we;
  logic          mem_rd;
  logic [W-1:0]  mem_rdata;
  head_op_e      head_op;

  apu_fifo_mem #(.DEPTH(DEPTH), .W(W)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wptr_reg),
    .wdata (bus.wdata),
    .raddr (rptr_reg),
    .rdata (mem_rdata)
  );

  // wrdy is a function of state only so the producer never sees a pop-dependent ready.
  always_comb begin
    pop    = en && bus.sample_rdy;
    wrdy   = en && !rst && (count_reg < CW'(DEPTH));
    xfer   = bus.wvalid && wrdy;
    bypass = xfer && (count_reg == '0) && (!head_valid_reg || pop);
    mem_we = xfer && !bypass;
  end

  always_comb begin
    head_op = HEAD_HOLD;
    if (head_valid_reg) begin
      if (pop) begin
        if (count_reg != '0) begin
          head_op = HEAD_FROM_MEM;
        end else if (bypass) begin
          head_op = HEAD_FROM_WDATA;
        end else begin
          head_op = HEAD_EMPTY;
        end
      end
    end else if ((count_reg != '0) && !pop) begin
      // Only after a flush race: never leave the head empty with data queued.
      head_op = HEAD_FROM_MEM;
    end else if (bypass) begin
      head_op = HEAD_FROM_WDATA;
    end
    mem_rd = (head_op == HEAD_FROM_MEM);
  end

  always_comb begin
    rptr_next       = rptr_reg;
    wptr_next       = wptr_reg;
    count_next      = count_reg;
    head_valid_next = head_valid_reg;
    sample_next     = sample_reg;
    underflow_next  = underflow_reg;

    if (mem_rd) rptr_next = rptr_reg + PW'(1);
    if (mem_we) wptr_next = wptr_reg + PW'(1);
    case ({mem_we, mem_rd})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase

    case (head_op)
      HEAD_FROM_MEM: begin
        sample_next     = mem_rdata;
        head_valid_next = 1'b1;
      end
      HEAD_FROM_WDATA: begin
        sample_next     = bus.wdata;
        head_valid_next = 1'b1;
      end
      HEAD_EMPTY:  head_valid_next = 1'b0;
      default:     head_valid_next = head_valid_reg;
    endcase

    if (pop && !head_valid_reg) begin
      underflow_next = 1'b1;
    end else if (underflow_clr) begin
      underflow_next = 1'b0;
    end

    // Disabled block flushes like a reset but keeps the sticky underflow.
    if (!en) begin
      rptr_next       = '0;
      wptr_next       = '0;
      count_next      = '0;
      head_valid_next = 1'b0;
      sample_next     = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rptr_reg       <= '0;
      wptr_reg       <= '0;
      count_reg      <= '0;
      head_valid_reg <= 1'b0;
      sample_reg     <= '0;
      underflow_reg  <= 1'b0;
    end else begin
      rptr_reg       <= rptr_next;
      wptr_reg       <= wptr_next;
      count_reg      <= count_next;
      head_valid_reg <= head_valid_next;
      sample_reg     <= sample_next;
      underflow_reg  <= underflow_next;
    end
  end

  assign bus.wrdy   = wrdy;
  assign bus.sample = sample_reg;
  assign level      = LW'(count_reg) + LW'(head_valid_reg);
  assign req_refill = en && (level <= lowwater);
  assign underflow  = underflow_reg;

endmodule
